// File: rtl/execute_muldiv_if.sv
// Decode/mem-facing bundle of the execute stage: decode class flags and
// operands in, forwarding taps from mem/wb, and the execute-to-mem register bank out.
interface execute_muldiv_if #(
    parameter int XLEN = 32
);
    logic            branch_flush;
    logic            jal_flush;
    logic            stall;
    logic [4:0]      regD_mem;
    logic [4:0]      regD_wb;
    logic [XLEN-1:0] regD_val_mem;
    logic [XLEN-1:0] regD_val_wb;
    logic            regwrite_mem;
    logic            regwrite_wb;
    logic            rtype;
    logic            itype;
    logic            load;
    logic            store;
    logic            branch;
    logic            jal;
    logic            jalr;
    logic            muldiv;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic [4:0]      reg1;
    logic [4:0]      reg2;
    logic [4:0]      regD;
    logic [XLEN-1:0] reg1val;
    logic [XLEN-1:0] reg2val;
    logic            regwrite;
    logic            loadF;
    logic            storeF;
    logic            jalF;
    logic            jalrF;
    logic            branch_cond;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] store_data;
    logic [4:0]      regDF;
    logic            busy;
    logic [4:0]      mshr_reg1;
    logic [4:0]      mshr_reg2;

    // Decode / mem side
    modport master (
        output branch_flush, jal_flush, stall, regD_mem, regD_wb, regD_val_mem, regD_val_wb,
               regwrite_mem, regwrite_wb, rtype, itype, load, store, branch, jal, jalr, muldiv,
               imm, pc, inst, reg1, reg2, regD, reg1val, reg2val,
        input  regwrite, loadF, storeF, jalF, jalrF, branch_cond, target, result, store_data,
               regDF, busy, mshr_reg1, mshr_reg2
    );

    // Execute stage side
    modport slave (
        input  branch_flush, jal_flush, stall, regD_mem, regD_wb, regD_val_mem, regD_val_wb,
               regwrite_mem, regwrite_wb, rtype, itype, load, store, branch, jal, jalr, muldiv,
               imm, pc, inst, reg1, reg2, regD, reg1val, reg2val,
        output regwrite, loadF, storeF, jalF, jalrF, branch_cond, target, result, store_data,
               regDF, busy, mshr_reg1, mshr_reg2
    );
endinterface

// File: rtl/execute_muldiv.sv
// Execute stage: single-cycle ALU/branch/jump/address path with mem/wb
// forwarding, plus an iterative RV32M multiply/divide unit that holds the
// front end through busy while it works.
module execute_muldiv #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input logic              clk,
    input logic              rst,
    execute_muldiv_if.slave  bus
);
    localparam int N   = XLEN / BITS_PER_CYCLE;
    localparam int SHW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef struct packed {
        logic            regwrite;
        logic            loadF;
        logic            storeF;
        logic            jalF;
        logic            jalrF;
        logic            branchCond;
        logic [XLEN-1:0] target;
        logic [XLEN-1:0] result;
        logic [XLEN-1:0] storeData;
        logic [4:0]      regDF;
    } outBank_t;

    state_t          state_q;
    logic [6:0]      count_q;
    logic            stallPrev_q;
    outBank_t        out_q;
    logic [XLEN-1:0] accHi_q, accHi_d;
    logic [XLEN-1:0] accLo_q, accLo_d;
    logic [XLEN-1:0] opB_q;
    logic [2:0]      funct3_q;
    logic [4:0]      mdRegD_q;
    logic            negA_q, negB_q, divZero_q;

    logic            flush;
    logic            postStall;
    logic [XLEN-1:0] rs1Fwd, rs2Fwd;
    logic [2:0]      funct3;
    logic            aSigned, bSigned, negA, negB;
    logic [XLEN-1:0] magA, magB;
    logic [XLEN-1:0] opnd, aluRes;
    logic [SHW-1:0]  shamt;
    logic            brTaken;
    outBank_t        aluOut, doneOut;
    logic [XLEN:0]   mulSum, divRem;
    logic [2*XLEN-1:0] prodFull;
    logic [XLEN-1:0] quot, remd, mdResult;
    logic            unusedInstBits;

    assign flush          = bus.branch_flush | bus.jal_flush;
    assign funct3         = bus.inst[14:12];
    assign unusedInstBits = ^{bus.inst[31], bus.inst[29:15], bus.inst[11:0]};

    // Operand forwarding: mem beats wb, x0 never forwarded, and right after
    // a stall releases only mem is trusted since wb has already been consumed.
    always_comb begin
        postStall = stallPrev_q & ~bus.stall;
        rs1Fwd    = bus.reg1val;
        rs2Fwd    = bus.reg2val;
        if (bus.reg1 != 5'd0) begin
            if (bus.regwrite_mem && bus.regD_mem == bus.reg1)
                rs1Fwd = bus.regD_val_mem;
            else if (!postStall && bus.regwrite_wb && bus.regD_wb == bus.reg1)
                rs1Fwd = bus.regD_val_wb;
        end
        if (bus.reg2 != 5'd0) begin
            if (bus.regwrite_mem && bus.regD_mem == bus.reg2)
                rs2Fwd = bus.regD_val_mem;
            else if (!postStall && bus.regwrite_wb && bus.regD_wb == bus.reg2)
                rs2Fwd = bus.regD_val_wb;
        end
    end

    // Single-cycle ALU, branch compare and address/link generation
    always_comb begin
        opnd   = bus.itype ? bus.imm : rs2Fwd;
        shamt  = opnd[SHW-1:0];
        aluRes = '0;
        case (funct3)
            3'b000: aluRes = (bus.rtype && bus.inst[30]) ? rs1Fwd - opnd : rs1Fwd + opnd;
            3'b001: aluRes = rs1Fwd << shamt;
            3'b010: aluRes = {{(XLEN-1){1'b0}}, ($signed(rs1Fwd) < $signed(opnd))};
            3'b011: aluRes = {{(XLEN-1){1'b0}}, (rs1Fwd < opnd)};
            3'b100: aluRes = rs1Fwd ^ opnd;
            3'b101: aluRes = bus.inst[30] ? $unsigned($signed(rs1Fwd) >>> shamt) : rs1Fwd >> shamt;
            3'b110: aluRes = rs1Fwd | opnd;
            default: aluRes = rs1Fwd & opnd;
        endcase
        brTaken = 1'b0;
        case (funct3)
            3'b000: brTaken = (rs1Fwd == rs2Fwd);
            3'b001: brTaken = (rs1Fwd != rs2Fwd);
            3'b100: brTaken = ($signed(rs1Fwd) < $signed(rs2Fwd));
            3'b101: brTaken = ($signed(rs1Fwd) >= $signed(rs2Fwd));
            3'b110: brTaken = (rs1Fwd < rs2Fwd);
            3'b111: brTaken = (rs1Fwd >= rs2Fwd);
            default: brTaken = 1'b0;
        endcase
        aluOut            = '0;
        aluOut.regwrite   = bus.rtype | bus.itype | bus.load | bus.jal | bus.jalr;
        aluOut.loadF      = bus.load;
        aluOut.storeF     = bus.store;
        aluOut.jalF       = bus.jal;
        aluOut.jalrF      = bus.jalr;
        aluOut.branchCond = bus.branch & brTaken;
        aluOut.target     = bus.jalr ? rs1Fwd + bus.imm : bus.pc + bus.imm;
        if (bus.load || bus.store)
            aluOut.result = rs1Fwd + bus.imm;
        else if (bus.jal || bus.jalr)
            aluOut.result = bus.pc + XLEN'(4);
        else
            aluOut.result = aluRes;
        aluOut.storeData  = rs2Fwd;
        aluOut.regDF      = bus.regD;
    end

    // Operand signedness and magnitudes captured when a muldiv is accepted
    always_comb begin
        aSigned = (funct3 == 3'b001) | (funct3 == 3'b010) | (funct3 == 3'b100) | (funct3 == 3'b110);
        bSigned = (funct3 == 3'b001) | (funct3 == 3'b100) | (funct3 == 3'b110);
        negA    = aSigned & rs1Fwd[XLEN-1];
        negB    = bSigned & rs2Fwd[XLEN-1];
        magA    = negA ? -rs1Fwd : rs1Fwd;
        magB    = negB ? -rs2Fwd : rs2Fwd;
    end

    // One iteration: BITS_PER_CYCLE shift-add or restoring-divide steps.
    // Multiply keeps the product in {accHi,accLo}; divide keeps the partial
    // remainder in accHi and shifts the dividend out of / quotient into accLo.
    always_comb begin
        accHi_d = accHi_q;
        accLo_d = accLo_q;
        mulSum  = '0;
        divRem  = '0;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            if (!funct3_q[2]) begin
                mulSum  = {1'b0, accHi_d} + (accLo_d[0] ? {1'b0, opB_q} : {(XLEN+1){1'b0}});
                accLo_d = {mulSum[0], accLo_d[XLEN-1:1]};
                accHi_d = mulSum[XLEN:1];
            end else begin
                divRem  = {accHi_d, accLo_d[XLEN-1]};
                accLo_d = {accLo_d[XLEN-2:0], 1'b0};
                if (divRem >= {1'b0, opB_q}) begin
                    divRem     = divRem - {1'b0, opB_q};
                    accLo_d[0] = 1'b1;
                end
                accHi_d = divRem[XLEN-1:0];
            end
        end
    end

    // Sign fixup and special cases applied to the finished magnitudes
    always_comb begin
        prodFull = {accHi_q, accLo_q};
        if (negA_q ^ negB_q)
            prodFull = -prodFull;
        quot = (negA_q ^ negB_q) ? -accLo_q : accLo_q;
        if (divZero_q)
            quot = '1;
        remd = negA_q ? -accHi_q : accHi_q;
        case (funct3_q)
            3'b000:                 mdResult = prodFull[XLEN-1:0];
            3'b001, 3'b010, 3'b011: mdResult = prodFull[2*XLEN-1:XLEN];
            3'b100, 3'b101:         mdResult = quot;
            default:                mdResult = remd;
        endcase
        doneOut          = '0;
        doneOut.regwrite = 1'b1;
        doneOut.result   = mdResult;
        doneOut.regDF    = mdRegD_q;
    end

    // Control FSM together with the execute-to-mem register bank
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            stallPrev_q <= 1'b0;
            out_q       <= '0;
            accHi_q     <= '0;
            accLo_q     <= '0;
            opB_q       <= '0;
            funct3_q    <= '0;
            mdRegD_q    <= '0;
            negA_q      <= 1'b0;
            negB_q      <= 1'b0;
            divZero_q   <= 1'b0;
        end else begin
            stallPrev_q <= bus.stall;
            if (flush) begin
                state_q <= IDLE;
                out_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (!bus.stall) begin
                            if (bus.muldiv) begin
                                funct3_q  <= funct3;
                                mdRegD_q  <= bus.regD;
                                negA_q    <= negA;
                                negB_q    <= negB;
                                divZero_q <= (rs2Fwd == '0);
                                accHi_q   <= '0;
                                accLo_q   <= funct3[2] ? magA : magB;
                                opB_q     <= funct3[2] ? magB : magA;
                                count_q   <= '0;
                                out_q     <= '0;
                                state_q   <= RUN;
                            end else begin
                                out_q <= aluOut;
                            end
                        end
                    end
                    RUN: begin
                        accHi_q <= accHi_d;
                        accLo_q <= accLo_d;
                        count_q <= count_q + 7'd1;
                        if (count_q == 7'(N - 1))
                            state_q <= DONE;
                    end
                    DONE: begin
                        if (!bus.stall) begin
                            out_q   <= doneOut;
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.busy = ~rst & ~flush &
                      (((state_q == IDLE) & bus.muldiv & ~bus.stall) | (state_q == RUN));

    assign bus.regwrite    = out_q.regwrite;
    assign bus.loadF       = out_q.loadF;
    assign bus.storeF      = out_q.storeF;
    assign bus.jalF        = out_q.jalF;
    assign bus.jalrF       = out_q.jalrF;
    assign bus.branch_cond = out_q.branchCond;
    assign bus.target      = out_q.target;
    assign bus.result      = out_q.result;
    assign bus.store_data  = out_q.storeData;
    assign bus.regDF       = out_q.regDF;
    assign bus.mshr_reg1   = bus.reg1;
    assign bus.mshr_reg2   = bus.reg2;
endmodule
